pwm_multi_gen: RTL and testbench

Parametrised multi-channel PWM generator that replaces the fixed 2-bit pwm_out path on the board-peripheral side of the Zed system. All channels share one prescaler and one period counter. Each channel has its own duty and polarity. Supports edge-aligned and center-aligned modes, with glitch-free shadow-register updates applied only at cycle boundaries.

---
 rtl/pwm_multi_gen.sv | 158 +++++++++++++++
 tb/tb_pwm_multi_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared prescaler and period counter, with
// per-channel duty/polarity. Config is shadowed and applied only at cycle boundaries.

module pwm_multi_gen_ch #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  input  logic [CNT_WIDTH-1:0] i_duty,
  input  logic                 i_pol,
  input  logic                 i_idle_pol,
  output logic                 o_pwm
);
  logic r_pwm;

  always_ff @(posedge clk) begin
    if (rst)       r_pwm <= 1'b0;
    else if (!i_en) r_pwm <= i_idle_pol;
    else           r_pwm <= (i_cnt < i_duty) ^ i_pol;
  end

  assign o_pwm = r_pwm;
endmodule

module pwm_multi_gen #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cfg_load,
  input  logic                        cfg_center,
  input  logic [PRE_WIDTH-1:0]        cfg_prescale,
  input  logic [CNT_WIDTH-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_duty,
  input  logic [NUM_CH-1:0]           cfg_polarity,
  output logic                        cfg_pending,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        cycle_start,
  output logic [CNT_WIDTH-1:0]        counter
);
  logic                              r_sh_center, r_act_center;
  logic [PRE_WIDTH-1:0]              r_sh_pre, r_act_pre;
  logic [CNT_WIDTH-1:0]              r_sh_period, r_act_period;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  r_sh_duty, r_act_duty;
  logic [NUM_CH-1:0]                 r_sh_pol, r_act_pol;

  logic [PRE_WIDTH-1:0] r_pre_cnt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_down;
  logic                 r_pending;
  logic                 r_cs;

  logic                 w_tick, w_wrap, w_apply, w_upd;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_down_nxt;
  logic [NUM_CH-1:0]    w_idle_pol;

  assign w_tick = enable && (r_pre_cnt == r_act_pre);

  // Center mode turns at period and at 0; period==1 turns straight back to up.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_down_nxt = r_down;
    if (r_act_period == '0) begin
      w_cnt_nxt  = '0;
      w_down_nxt = 1'b0;
    end else if (!r_act_center) begin
      w_cnt_nxt  = (r_cnt >= r_act_period) ? '0 : r_cnt + 1'b1;
      w_down_nxt = 1'b0;
    end else if (!r_down) begin
      if (r_cnt >= r_act_period) begin
        w_cnt_nxt  = r_act_period - 1'b1;
        w_down_nxt = (r_act_period != CNT_WIDTH'(1));
      end else begin
        w_cnt_nxt  = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_nxt  = r_cnt - 1'b1;
      w_down_nxt = (r_cnt != CNT_WIDTH'(1));
    end
  end

  assign w_wrap  = w_tick && (w_cnt_nxt == '0);
  // While stopped every clk is a boundary, so a pending or fresh config lands at once.
  assign w_apply = !enable || w_wrap;
  assign w_upd   = w_apply && (r_pending || cfg_load);
  assign w_idle_pol = w_upd ? (cfg_load ? cfg_polarity : r_sh_pol) : r_act_pol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_center  <= 1'b0;
      r_sh_pre     <= '0;
      r_sh_period  <= '0;
      r_sh_duty    <= '0;
      r_sh_pol     <= '0;
      r_act_center <= 1'b0;
      r_act_pre    <= '0;
      r_act_period <= '0;
      r_act_duty   <= '0;
      r_act_pol    <= '0;
      r_pre_cnt    <= '0;
      r_cnt        <= '0;
      r_down       <= 1'b0;
      r_pending    <= 1'b0;
      r_cs         <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_sh_center <= cfg_center;
        r_sh_pre    <= cfg_prescale;
        r_sh_period <= cfg_period;
        r_sh_duty   <= cfg_duty;
        r_sh_pol    <= cfg_polarity;
      end
      if (w_upd) begin
        r_act_center <= cfg_load ? cfg_center   : r_sh_center;
        r_act_pre    <= cfg_load ? cfg_prescale : r_sh_pre;
        r_act_period <= cfg_load ? cfg_period   : r_sh_period;
        r_act_duty   <= cfg_load ? cfg_duty     : r_sh_duty;
        r_act_pol    <= cfg_load ? cfg_polarity : r_sh_pol;
      end
      r_pending <= w_apply ? 1'b0 : (r_pending | cfg_load);
      r_cs      <= w_wrap;
      if (!enable) begin
        r_pre_cnt <= '0;
        r_cnt     <= '0;
        r_down    <= 1'b0;
      end else if (w_tick) begin
        r_pre_cnt <= '0;
        r_cnt     <= w_cnt_nxt;
        r_down    <= w_down_nxt;
      end else begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_multi_gen_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_en       (enable),
      .i_cnt      (r_cnt),
      .i_duty     (r_act_duty[k]),
      .i_pol      (r_act_pol[k]),
      .i_idle_pol (w_idle_pol[k]),
      .o_pwm      (pwm_out[k])
    );
  end

  assign cfg_pending = r_pending;
  assign cycle_start = r_cs;
  assign counter     = r_cnt;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: a cycle-phase reference model checked every clk,
// plus directed scenarios with hand-computed expectations.

module tb_pwm_multi_gen;
  localparam int NC = 2;
  localparam int CW = 16;
  localparam int PW = 8;

  logic              clk = 1'b0;
  logic              rst, enable, cfg_load, cfg_center;
  logic [PW-1:0]     cfg_prescale;
  logic [CW-1:0]     cfg_period;
  logic [NC*CW-1:0]  cfg_duty;
  logic [NC-1:0]     cfg_polarity;
  logic              cfg_pending, cycle_start;
  logic [NC-1:0]     pwm_out;
  logic [CW-1:0]     counter;

  pwm_multi_gen #(.NUM_CH(NC), .CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load),
    .cfg_center(cfg_center), .cfg_prescale(cfg_prescale), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_polarity(cfg_polarity), .cfg_pending(cfg_pending),
    .pwm_out(pwm_out), .cycle_start(cycle_start), .counter(counter)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                   center;
    logic [PW-1:0]          pre;
    logic [CW-1:0]          period;
    logic [NC-1:0][CW-1:0]  duty;
    logic [NC-1:0]          pol;
  } cfg_t;

  int checks = 0;
  int errors = 0;

  // Model: position within the current cycle (phase) rather than counter+direction.
  cfg_t        m_act, m_sh;
  int          m_pre, m_p, m_cnt;
  logic        m_pend, m_cs, m_valid = 1'b0;
  logic [NC-1:0] m_pwm;

  function automatic int cyc_len(cfg_t c);
    if (c.period == 0) return 1;
    return c.center ? 2 * int'(c.period) : int'(c.period) + 1;
  endfunction

  function automatic int cnt_of(cfg_t c, int p);
    if (!c.center) return p;
    return (p <= int'(c.period)) ? p : 2 * int'(c.period) - p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    cfg_t inc, nact;
    int cur, len;
    logic tick, wrap, apply;
    inc = {cfg_center, cfg_prescale, cfg_period, cfg_duty, cfg_polarity};
    m_valid = 1'b1;
    if (rst) begin
      m_act = '0; m_sh = '0; m_pre = 0; m_p = 0;
      m_pend = 0; m_cs = 0; m_pwm = '0; m_cnt = 0;
      return;
    end
    cur   = cnt_of(m_act, m_p);
    len   = cyc_len(m_act);
    tick  = enable && (m_pre == int'(m_act.pre));
    wrap  = tick && (((m_p + 1) % len) == 0);
    apply = !enable || wrap;
    nact  = apply ? (cfg_load ? inc : m_sh) : m_act;
    for (int k = 0; k < NC; k++)
      m_pwm[k] = enable ? ((cur < int'(m_act.duty[k])) ^ m_act.pol[k]) : nact.pol[k];
    m_cs  = wrap;
    m_pre = enable ? (tick ? 0 : m_pre + 1) : 0;
    m_p   = enable ? (tick ? (m_p + 1) % len : m_p) : 0;
    if (cfg_load) m_sh = inc;
    m_pend = apply ? 1'b0 : (cfg_load ? 1'b1 : m_pend);
    m_act = nact;
    m_cnt = cnt_of(m_act, m_p);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("counter", 32'(counter), 32'(m_cnt));
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
      chk("cycle_start", 32'(cycle_start), 32'(m_cs));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load(input logic c, input int pre, input int per, input int d0, input int d1,
                      input logic [NC-1:0] pol);
    cfg_center   = c;
    cfg_prescale = PW'(pre);
    cfg_period   = CW'(per);
    cfg_duty     = {CW'(d1), CW'(d0)};
    cfg_polarity = pol;
    cfg_load     = 1'b1;
    step();
    cfg_load     = 1'b0;
  endtask

  task automatic wait_cs(input int lim);
    for (int i = 0; i < lim; i++) begin
      step();
      if (cycle_start) return;
    end
    checks++; errors++;
    $display("FAIL wait_cs: no cycle_start within %0d clks", lim);
  endtask

  task automatic wait_cnt(input int v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (int'(counter) == v) return;
      step();
    end
    checks++; errors++;
    $display("FAIL wait_cnt: counter %0d never seen within %0d clks", v, lim);
  endtask

  initial begin
    int hi, hi1, cs_n, n;
    int cseq [16] = '{0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1};
    rst = 1; enable = 0; cfg_load = 0; cfg_center = 0;
    cfg_prescale = '0; cfg_period = '0; cfg_duty = '0; cfg_polarity = '0;
    step(); step();
    rst = 0;
    chk("rst_counter", 32'(counter), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_cs", 32'(cycle_start), 0);
    chk("rst_pending", 32'(cfg_pending), 0);

    // Edge mode, period 4, duty0 2, duty1 5 (> period)
    load(0, 0, 4, 2, 5, 2'b00);
    chk("load_while_disabled_pending", 32'(cfg_pending), 0);
    enable = 1;
    wait_cs(20);
    hi = 0; hi1 = 0;
    for (int i = 0; i < 5; i++) begin step(); hi += pwm_out[0]; hi1 += pwm_out[1]; end
    chk("edge_high_clks", hi, 2);
    chk("duty_gt_period_high", hi1, 5);
    cs_n = 0;
    for (int i = 0; i < 10; i++) begin step(); cs_n += cycle_start; end
    chk("edge_cs_per_10", cs_n, 2);

    // Center mode, prescale 1
    load(1, 1, 4, 2, 0, 2'b00);
    chk("center_load_pending", 32'(cfg_pending), 1);
    wait_cs(40);
    chk("center_applied_pending", 32'(cfg_pending), 0);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      chk("center_seq", 32'(counter), 32'(cseq[i]));
      step();
      hi += pwm_out[0];
    end
    chk("center_high_clks", hi, 6);

    // Mid-cycle duty update
    load(0, 0, 4, 2, 5, 2'b00);
    wait_cs(40);
    wait_cnt(2, 20);
    load(0, 0, 4, 3, 5, 2'b00);
    chk("midcycle_pending", 32'(cfg_pending), 1);
    chk("old_duty_kept", 32'(pwm_out[0]), 0);
    wait_cs(20);
    chk("boundary_pending_clear", 32'(cfg_pending), 0);
    hi = 0;
    for (int i = 0; i < 5; i++) begin step(); hi += pwm_out[0]; end
    chk("new_duty_high_clks", hi, 3);

    // duty0 = 0 and inverted channel 1
    load(0, 0, 4, 0, 2, 2'b10);
    wait_cs(20);
    hi = 0; hi1 = 0;
    for (int i = 0; i < 5; i++) begin step(); hi += pwm_out[0]; hi1 += pwm_out[1]; end
    chk("duty0_zero_high", hi, 0);
    chk("pol1_inverted_high", hi1, 3);

    // period 0
    load(0, 0, 0, 1, 0, 2'b00);
    wait_cs(20);
    cs_n = 0; hi = 0;
    for (int i = 0; i < 6; i++) begin step(); cs_n += cycle_start; hi += pwm_out[0]; end
    chk("period0_cs", cs_n, 6);
    chk("period0_duty1_high", hi, 6);

    // Drop enable with config pending, then re-enable with prescale 2
    load(0, 0, 4, 2, 0, 2'b00);
    wait_cs(20);
    wait_cnt(2, 20);
    load(0, 2, 4, 2, 0, 2'b01);
    enable = 0;
    step();
    chk("disable_pwm_pol", 32'(pwm_out), 32'h1);
    chk("disable_counter", 32'(counter), 0);
    chk("disable_pending", 32'(cfg_pending), 0);
    chk("disable_cs", 32'(cycle_start), 0);
    step(); step();
    enable = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(); n++;
      if (counter != 0) break;
    end
    chk("reenable_first_inc", n, 3);

    // Reset mid-cycle with a pending config
    wait_cnt(2, 40);
    load(0, 2, 4, 3, 0, 2'b00);
    wait_cnt(3, 10);
    chk("pre_rst_pending", 32'(cfg_pending), 1);
    rst = 1;
    step();
    chk("midrst_counter", 32'(counter), 0);
    chk("midrst_pwm", 32'(pwm_out), 0);
    chk("midrst_cs", 32'(cycle_start), 0);
    chk("midrst_pending", 32'(cfg_pending), 0);
    rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cfg_load = ($urandom_range(0, 15) == 0);
      if (cfg_load) begin
        cfg_center   = 1'($urandom_range(0, 1));
        cfg_prescale = PW'($urandom_range(0, 3));
        cfg_period   = CW'($urandom_range(0, 6));
        cfg_duty     = {CW'($urandom_range(0, 8)), CW'($urandom_range(0, 8))};
        cfg_polarity = NC'($urandom_range(0, 3));
      end
      if (enable && $urandom_range(0, 39) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
      step();
    end
    rst = 0; cfg_load = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
